// File: rtl/pad_insert.sv
// pad_insert: re-expands a compact row-major H x W tile into padded rows.
// Every row gets pad_left zero columns in front and pad_right zero columns
// behind it. Input and output both carry GROUP_SIZE pixels per word, and the
// whole tile is repeated num_iters times (for example once per channel).
//
// Ports
//   clk, rst         clock; synchronous active-low reset
//   configure        one-cycle pulse that loads num_iters/h/w/pad_left/pad_right
//                    (taken only in IDLE with no output word pending)
//   data_in/valid_in input word write; avail_out = room for another word
//   data_out/valid_out/avail_in  output word handshake
//                    (valid_out = pending & avail_in)
//   busy             high while RUN or FLUSH
module pad_insert #(
  parameter int GROUP_SIZE    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int LOG_MAX_DIM   = 8,
  parameter int LOG_MAX_ITERS = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             configure,
  input  logic [LOG_MAX_ITERS-1:0]         num_iters,
  input  logic [LOG_MAX_DIM-1:0]           h,
  input  logic [LOG_MAX_DIM-1:0]           w,
  input  logic [LOG_MAX_DIM-1:0]           pad_left,
  input  logic [LOG_MAX_DIM-1:0]           pad_right,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in,
  input  logic                             valid_in,
  output logic                             avail_out,
  output logic [GROUP_SIZE*DATA_WIDTH-1:0] data_out,
  output logic                             valid_out,
  input  logic                             avail_in,
  output logic                             busy
);

  localparam int IDX_W  = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
  localparam int DIM1_W = LOG_MAX_DIM + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
  typedef logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0] word_t;

  // ---------------------------------------------------------------- state
  state_t                   state_q, state_d;
  logic [LOG_MAX_ITERS-1:0] num_iters_q, num_iters_d;
  logic [LOG_MAX_ITERS-1:0] iter_q, iter_d;
  logic [LOG_MAX_DIM-1:0]   h_q, h_d, w_q, w_d, pl_q, pl_d;
  logic [DIM1_W-1:0]        wp_q, wp_d;
  logic [LOG_MAX_DIM-1:0]   row_q, row_d;
  logic [DIM1_W-1:0]        col_q, col_d;
  logic [IDX_W-1:0]         in_idx_q, in_idx_d, out_idx_q, out_idx_d;
  word_t                    asm_q, asm_d, out_q, out_d;
  logic                     out_pend_q, out_pend_d;

  // 4-entry input FIFO
  word_t                    fifo_q [4];
  word_t                    fifo_d [4];
  logic [1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]               cnt_q, cnt_d;

  // ---------------------------------------------------------------- comb
  logic              push, pop, fifo_empty, drain;
  logic              c_real, last_row, last_col, last_real, word_done, stall, iter_end;
  logic [DIM1_W-1:0] real_end, wp_in;
  word_t             head;

  assign fifo_empty = (cnt_q == 3'd0);
  // Stop advertising room one word early so a write in flight still fits.
  assign avail_out  = (cnt_q < 3'd3);
  // A write while full is a protocol error; the word is simply dropped.
  assign push       = valid_in & (cnt_q != 3'd4);
  assign head       = fifo_q[rd_ptr_q];

  assign drain      = out_pend_q & avail_in;
  assign valid_out  = drain;
  assign data_out   = out_q;
  assign busy       = (state_q != S_IDLE);

  assign wp_in      = DIM1_W'(pad_left) + DIM1_W'(w) + DIM1_W'(pad_right);
  assign real_end   = DIM1_W'(pl_q) + DIM1_W'(w_q);
  assign c_real     = (col_q >= DIM1_W'(pl_q)) && (col_q < real_end);
  assign last_row   = (row_q == h_q - LOG_MAX_DIM'(1));
  assign last_col   = (col_q == wp_q - DIM1_W'(1));
  assign last_real  = last_row && (col_q == real_end - DIM1_W'(1));
  assign word_done  = (out_idx_q == LAST_IDX);
  // Hold position when a pixel is needed but none is queued, or when this
  // position would finish a word and the output register cannot take it.
  assign stall      = (c_real & fifo_empty) | (word_done & out_pend_q & ~avail_in);

  always_comb begin
    state_d     = state_q;
    num_iters_d = num_iters_q;
    iter_d      = iter_q;
    h_d         = h_q;
    w_d         = w_q;
    pl_d        = pl_q;
    wp_d        = wp_q;
    row_d       = row_q;
    col_d       = col_q;
    in_idx_d    = in_idx_q;
    out_idx_d   = out_idx_q;
    asm_d       = asm_q;
    out_d       = out_q;
    out_pend_d  = out_pend_q & ~drain;
    pop         = 1'b0;
    iter_end    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The previous tile's last word must have left before reconfiguring.
        if (configure && !out_pend_q) begin
          num_iters_d = num_iters;
          h_d         = h;
          w_d         = w;
          pl_d        = pad_left;
          wp_d        = wp_in;
          row_d       = '0;
          col_d       = '0;
          in_idx_d    = '0;
          out_idx_d   = '0;
          iter_d      = '0;
          if (num_iters != '0 && h != '0 && wp_in != '0) state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (!stall) begin
          asm_d[out_idx_q] = c_real ? head[in_idx_q] : '0;
          if (c_real) begin
            // The tile's final pixel may sit mid-word; the rest is filler.
            if (in_idx_q == LAST_IDX || last_real) begin
              pop      = 1'b1;
              in_idx_d = '0;
            end else begin
              in_idx_d = in_idx_q + IDX_W'(1);
            end
          end
          if (word_done) begin
            out_d      = asm_d;
            out_pend_d = 1'b1;
            out_idx_d  = '0;
          end else begin
            out_idx_d  = out_idx_q + IDX_W'(1);
          end
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d = '0;
              if (word_done) iter_end = 1'b1;
              else           state_d  = S_FLUSH;
            end else begin
              row_d = row_q + LOG_MAX_DIM'(1);
            end
          end else begin
            col_d = col_q + DIM1_W'(1);
          end
        end
      end

      S_FLUSH: begin
        // Emit the partial word with its unfilled slots forced to zero.
        if (!out_pend_q || avail_in) begin
          for (int k = 0; k < GROUP_SIZE; k++)
            out_d[k] = (k < int'(out_idx_q)) ? asm_q[k] : '0;
          out_pend_d = 1'b1;
          out_idx_d  = '0;
          iter_end   = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (iter_end) begin
      iter_d  = iter_q + LOG_MAX_ITERS'(1);
      state_d = (iter_d == num_iters_q) ? S_IDLE : S_RUN;
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = data_in;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    cnt_d = cnt_q + 3'(push) - 3'(pop);
  end

  // ---------------------------------------------------------------- flops
  // FIFO storage needs no reset: the count and pointers define its contents.
  always_ff @(posedge clk) fifo_q <= fifo_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      num_iters_q <= '0;
      iter_q      <= '0;
      h_q         <= '0;
      w_q         <= '0;
      pl_q        <= '0;
      wp_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      asm_q       <= '0;
      out_q       <= '0;
      out_pend_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      num_iters_q <= num_iters_d;
      iter_q      <= iter_d;
      h_q         <= h_d;
      w_q         <= w_d;
      pl_q        <= pl_d;
      wp_q        <= wp_d;
      row_q       <= row_d;
      col_q       <= col_d;
      in_idx_q    <= in_idx_d;
      out_idx_q   <= out_idx_d;
      asm_q       <= asm_d;
      out_q       <= out_d;
      out_pend_q  <= out_pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pad_insert.sv
// Directed bench for pad_insert with GROUP_SIZE=4, DATA_WIDTH=8.
module tb_pad_insert;
  localparam int GS = 4;
  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        configure = 1'b0;
  logic [15:0] num_iters = '0;
  logic [7:0]  h = '0, w = '0, pad_left = '0, pad_right = '0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        avail_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        avail_in = 1'b1;
  logic        busy;

  always #5 clk = ~clk;

  pad_insert #(.GROUP_SIZE(GS), .DATA_WIDTH(DW), .LOG_MAX_DIM(8), .LOG_MAX_ITERS(16)) dut (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .h(h), .w(w), .pad_left(pad_left), .pad_right(pad_right),
    .data_in(data_in), .valid_in(valid_in), .avail_out(avail_out),
    .data_out(data_out), .valid_out(valid_out), .avail_in(avail_in), .busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // slot 0 is the least significant byte
  function automatic logic [31:0] w4(input logic [7:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  typedef struct packed {
    logic [7:0]       h, w, pl, pr;
    logic [15:0]      iters;
    logic [31:0]      n_in, n_out;
    logic [7:0][31:0] din;
    logic [7:0][31:0] dout;
  } vec_t;

  vec_t tbl [5];

  // Output monitor samples just before each rising edge.
  logic [31:0] got [$];
  always begin
    @(negedge clk);
    #4;
    if (valid_out) got.push_back(data_out);
  end

  // All tasks are entered at a falling edge.
  task automatic push_word(input logic [31:0] wd);
    int t = 0;
    while (!avail_out && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!avail_out) begin
      chk("push_timeout", avail_out, 1);
      return;
    end
    valid_in = 1'b1;
    data_in  = wd;
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = '0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (got.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("out_count", got.size(), n);
  endtask

  task automatic cfg(input logic [7:0] hh, ww, pl, pr, input logic [15:0] it);
    h = hh; w = ww; pad_left = pl; pad_right = pr; num_iters = it;
    configure = 1'b1;
    @(negedge clk);
    configure = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = tbl[i];
    got.delete();
    cfg(v.h, v.w, v.pl, v.pr, v.iters);
    chk($sformatf("v%0d_busy_start", i), busy, 1);
    for (int k = 0; k < int'(v.n_in); k++) push_word(v.din[k]);
    wait_out(int'(v.n_out));
    repeat (10) @(negedge clk);
    chk($sformatf("v%0d_nout", i), got.size(), v.n_out);
    for (int k = 0; k < int'(v.n_out); k++)
      chk($sformatf("v%0d_word%0d", i, k), (k < got.size()) ? got[k] : 32'hxxxxxxxx, v.dout[k]);
    chk($sformatf("v%0d_busy_end", i), busy, 0);
    chk($sformatf("v%0d_avail_end", i), avail_out, 1);
  endtask

  initial begin
    // V0: 3x3, two zero columns in front of each row
    tbl[0] = '0;
    tbl[0].h = 3; tbl[0].w = 3; tbl[0].pl = 2; tbl[0].pr = 0; tbl[0].iters = 1;
    tbl[0].n_in = 3; tbl[0].n_out = 4;
    tbl[0].din[0]  = w4(8'h10, 8'h11, 8'h12, 8'h13);
    tbl[0].din[1]  = w4(8'h14, 8'h15, 8'h16, 8'h17);
    tbl[0].din[2]  = w4(8'h18, 8'hEE, 8'hEE, 8'hEE);
    tbl[0].dout[0] = w4(8'h00, 8'h00, 8'h10, 8'h11);
    tbl[0].dout[1] = w4(8'h12, 8'h00, 8'h00, 8'h13);
    tbl[0].dout[2] = w4(8'h14, 8'h15, 8'h00, 8'h00);
    tbl[0].dout[3] = w4(8'h16, 8'h17, 8'h18, 8'h00);
    // V1: same tile, two iterations
    tbl[1] = tbl[0];
    tbl[1].iters = 2; tbl[1].n_in = 6; tbl[1].n_out = 8;
    tbl[1].din[3]  = w4(8'h20, 8'h21, 8'h22, 8'h23);
    tbl[1].din[4]  = w4(8'h24, 8'h25, 8'h26, 8'h27);
    tbl[1].din[5]  = w4(8'h28, 8'hEE, 8'hEE, 8'hEE);
    tbl[1].dout[4] = w4(8'h00, 8'h00, 8'h20, 8'h21);
    tbl[1].dout[5] = w4(8'h22, 8'h00, 8'h00, 8'h23);
    tbl[1].dout[6] = w4(8'h24, 8'h25, 8'h00, 8'h00);
    tbl[1].dout[7] = w4(8'h26, 8'h27, 8'h28, 8'h00);
    // V2: no padding, pass-through
    tbl[2] = '0;
    tbl[2].h = 2; tbl[2].w = 4; tbl[2].iters = 1; tbl[2].n_in = 2; tbl[2].n_out = 2;
    tbl[2].din[0]  = w4(8'h50, 8'h51, 8'h52, 8'h53);
    tbl[2].din[1]  = w4(8'h54, 8'h55, 8'h56, 8'h57);
    tbl[2].dout[0] = tbl[2].din[0];
    tbl[2].dout[1] = tbl[2].din[1];
    // V3: zero-width tile, padding only
    tbl[3] = '0;
    tbl[3].h = 2; tbl[3].w = 0; tbl[3].pl = 1; tbl[3].pr = 1; tbl[3].iters = 1;
    tbl[3].n_in = 0; tbl[3].n_out = 1;
    tbl[3].dout[0] = 32'h0;
    // V4: one row, pads on both sides, last input word partly filler
    tbl[4] = '0;
    tbl[4].h = 1; tbl[4].w = 5; tbl[4].pl = 1; tbl[4].pr = 2; tbl[4].iters = 1;
    tbl[4].n_in = 2; tbl[4].n_out = 2;
    tbl[4].din[0]  = w4(8'h30, 8'h31, 8'h32, 8'h33);
    tbl[4].din[1]  = w4(8'h34, 8'hEE, 8'hEE, 8'hEE);
    tbl[4].dout[0] = w4(8'h00, 8'h30, 8'h31, 8'h32);
    tbl[4].dout[1] = w4(8'h33, 8'h34, 8'h00, 8'h00);

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out",  data_out, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_avail_out", avail_out, 1);

    for (int i = 0; i < 5; i++) apply_vec(i);

    // h = 0 never leaves IDLE
    got.delete();
    cfg(8'd0, 8'd3, 8'd2, 8'd0, 16'd1);
    chk("h0_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("h0_busy_later", busy, 0);
    chk("h0_no_output", got.size(), 0);

    // downstream back-pressure mid-tile: 6x4 pass-through
    got.delete();
    cfg(8'd6, 8'd4, 8'd0, 8'd0, 16'd1);
    push_word(w4(8'h40, 8'h41, 8'h42, 8'h43));
    wait_out(1);
    avail_in = 1'b0;
    fork
      begin
        for (int k = 1; k < 6; k++)
          push_word(w4(8'(8'h40 + 4*k), 8'(8'h41 + 4*k), 8'(8'h42 + 4*k), 8'(8'h43 + 4*k)));
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          chk($sformatf("bp_valid_out%0d", c), valid_out, 0);
        end
        chk("bp_avail_out_low", avail_out, 0);
        chk("bp_held_count", got.size(), 1);
        avail_in = 1'b1;
      end
    join
    wait_out(6);
    repeat (5) @(negedge clk);
    chk("bp_nout", got.size(), 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("bp_word%0d", k), (k < got.size()) ? got[k] : 32'hxxxxxxxx,
          w4(8'(8'h40 + 4*k), 8'(8'h41 + 4*k), 8'(8'h42 + 4*k), 8'(8'h43 + 4*k)));
    chk("bp_busy_end", busy, 0);

    // reset mid-tile, then a clean rerun
    got.delete();
    cfg(8'd3, 8'd3, 8'd2, 8'd0, 16'd1);
    push_word(tbl[0].din[0]);
    push_word(tbl[0].din[1]);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid_out", valid_out, 0);
    chk("mid_rst_avail_out", avail_out, 1);
    chk("mid_rst_busy",      busy, 0);
    chk("mid_rst_data_out",  data_out, 0);
    rst = 1'b1;
    @(negedge clk);
    apply_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pad_insert.md
# pad_insert

Inverse of the alignment stage: takes a compact, row-major stream of an H×W tile packed GROUP_SIZE pixels per word and re-emits it with pad_left zero columns before and pad_right zero columns after every row. Output is regrouped into GROUP_SIZE-pixel words. It repeats this for num_iters iterations, for example one per channel. It sits upstream of the align stage and uses the same valid/avail word interface on both sides.

## Interface
- GROUP_SIZE, 8, pixels per word
- DATA_WIDTH, 8, bits per pixel
- LOG_MAX_DIM, 8, width of h, w, pad_left, pad_right
- LOG_MAX_ITERS, 16, width of num_iters

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- configure  in  1  one-cycle configure pulse, accepted only in IDLE
- num_iters  in  LOG_MAX_ITERS  iterations
- h, w  in  LOG_MAX_DIM  tile rows / real columns
- pad_left, pad_right  in  LOG_MAX_DIM  zero columns per row
- data_in  in  GROUP_SIZE*DATA_WIDTH  input word; slot k = bits [k*DATA_WIDTH +: DATA_WIDTH]
- valid_in  in  1  input word write
- avail_out  out  1  upstream may write
- data_out  out  GROUP_SIZE*DATA_WIDTH  output word, same slot order
- valid_out  out  1  output word transfer
- avail_in  in  1  downstream can accept
- busy  out  1  high in RUN or FLUSH

## Operation
- Input FIFO: 4 slots. avail_out = ~full & ~almost_full, where almost_full means 3 slots occupied. valid_in while full is a protocol error; the word is dropped.
- Padded row width wp = pad_left + w + pad_right, computed at LOG_MAX_DIM+1 bits.
- States: IDLE, RUN, FLUSH.
- IDLE → RUN on configure when num_iters≠0, h≠0 and wp≠0. Otherwise stays IDLE.
- Configure loads all config registers and clears row, col, in_idx, out_idx and the iteration count.
- RUN processes one output position (row r, col c) per cycle unless stalled.
  - c < pad_left or c ≥ pad_left+w: write 0 into assembly slot out_idx.
  - Otherwise: needs the FIFO non-empty. Writes head slot in_idx, then in_idx++.
  - Pop the FIFO head and set in_idx=0 when in_idx reaches GROUP_SIZE, or when the last real pixel of the iteration is consumed. Remaining slots of that word are discarded.
- Assembly: out_idx++ per position. When slot GROUP_SIZE-1 is written, the word moves to the output register, out_pend=1, and out_idx=0.
- Stall, meaning no position is processed, when:
  - a real pixel is needed and the FIFO is empty; or
  - the word would complete while out_pend=1 and it is not being drained this cycle.
- Counters: c wraps at wp-1 to 0 with r++. After the last position (r=h-1, c=wp-1):
  - out_idx≠0: go to FLUSH.
  - Otherwise end the iteration.
- FLUSH: unfilled slots are 0. The word moves to the output register once it is free, then the iteration ends.
- End of iteration: iteration count++. Equal to num_iters → IDLE, else RUN with r=c=0.
- Per iteration: input words = ceil(h*w/GS); output words = ceil(h*wp/GS).

## Timing
- Reset values: valid_out=0, data_out=0, busy=0, avail_out=1, FIFO empty, state IDLE.
- valid_out = out_pend & avail_in (combinational). On valid_out, out_pend clears that edge. A completing word may load the output register in the same cycle with no bubble.
- data_out holds the last word when valid_out=0.
- Latency: first input word written at edge t becomes FIFO-visible at t+1. The first output word reaches the output register after GROUP_SIZE processing cycles.
- Throughput: 1 position/cycle, so 1 output word per GROUP_SIZE cycles when not stalled.
- The config→RUN transition takes effect at the next edge. busy is high from the cycle after configure until the edge on which the final word loads the output register.
- After the last iteration the final word may still be pending in IDLE. It drains normally, and configure waits for out_pend=0.
- Reset mid-operation returns all state to reset values on that edge and drops any FIFO contents.

## Test plan
- GS=4, h=w=3, pad_left=2, pad_right=0, num_iters=1; inputs p0..p3, p4..p7, {p8,0,0,0}, avail_in=1 → 4 outputs: {0,0,p0,p1}, {p2,0,0,p3}, {p4,p5,0,0}, {p6,p7,p8,0}; then busy=0.
- Same config, num_iters=2, 6 input words → 8 outputs; second iteration starts at in_idx=0, out_idx=0.
- GS=4, h=2, w=4, pad_left=pad_right=0 → outputs equal inputs word-for-word; FLUSH never entered.
- avail_in held low 20 cycles mid-tile → valid_out=0 throughout, FIFO fills, avail_out=0 once 3 words are queued, no data lost; release → remaining words delivered in order.
- h=2, w=0, pad_left=1, pad_right=1, GS=4 → no input consumed, one output {0,0,0,0}; h=0 → stays IDLE, busy=0.
- rst low mid-tile → next cycle valid_out=0, avail_out=1, busy=0; new configure runs the first scenario correctly.
